alu_multicycle: RTL
===================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH, default 16, datapath width; legal values are powers of two from 4 to 64.
REQ-002 Derived constant SW = log2(WIDTH), the width of the shift-amount field.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request; sampled on rising clk.
REQ-006 op  input  3  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B; for SHL/SHR only b[SW-1:0] is used, as the shift amount n.
REQ-009 cin  input  1  carry in for ADD/SUB.
REQ-010 busy  output  1  high while a multi-cycle operation is in progress.
REQ-011 done  output  1  one-cycle pulse: y/cout/zout updated this cycle.
REQ-012 y  output  WIDTH  registered result.
REQ-013 cout  output  1  registered carry/flag out.
REQ-014 zout  output  1  registered zero flag; equals (y == 0).

Function
REQ-015 FSM states are IDLE, SHIFT, MUL; busy = (state != IDLE).
REQ-016 An accept occurs on an edge where start=1 and busy=0; op, a, b and cin are latched on that edge.
REQ-017 When start=1 while busy=1, the request is ignored and not queued.
REQ-018 ADD (single cycle): y = a+b+cin mod 2^WIDTH; cout = carry out of the MSB.
REQ-019 SUB (single cycle): y = a + ~b + cin mod 2^WIDTH; cout = carry out of the MSB (1 = no borrow when cin=1).
REQ-020 AND/OR/XOR (single cycle): bitwise result; cout = 0.
REQ-021 Single-cycle ops: y/cout/zout and done=1 are valid after the accepting edge, the state stays IDLE, and back-to-back accepts every cycle are allowed.
REQ-022 SHL/SHR with n=0: treated as single cycle, y = a, cout = 0.
REQ-023 SHL/SHR with n>0: enter SHIFT and shift one bit per cycle, filling with 0 (logical); after n cycles, y = the shifted value, cout = the last bit shifted out, done=1, and the state returns to IDLE.
REQ-024 Shift latency: done is asserted after edge k+n, where k is the accepting edge; busy is high after edges k..k+n-1.
REQ-025 MUL: shift-add over WIDTH cycles in MUL state; y = low WIDTH bits of a*b (unsigned); cout = 1 iff the high WIDTH bits of the product are nonzero; done is asserted after edge k+WIDTH.
REQ-026 In the cycle done=1, busy=0; a start in that cycle is accepted on the next edge.
REQ-027 y/cout/zout change only on completion and hold their values between completions; intermediate shift and multiply values are never visible on y.
REQ-028 done is 0 in every cycle except the single completion cycle.
REQ-029 zout is computed from the final y in the same update; it is never derived from intermediates.

Reset
REQ-030 reset=1 forces, asynchronously: state=IDLE, busy=0, done=0, y=0, cout=0, zout=1, and clears all internal counters and operand registers.
REQ-031 Reset during SHIFT or MUL aborts the operation, with no done pulse; the first accept after reset release starts cleanly.
REQ-032 start is ignored while reset=1.

Verification
REQ-033 WIDTH=16, ADD a=FFFF b=0001 cin=0 -> after 1 edge: y=0000, cout=1, zout=1, done=1, busy=0.
REQ-034 SUB a=0005 b=0007 cin=1 -> y=FFFE, cout=0, zout=0; then a back-to-back AND a=00F0 b=0F0F on the next cycle -> y=0000, zout=1, with two consecutive done pulses.
REQ-035 SHL a=8001 b=0003 -> busy for 3 cycles, done after edge k+3: y=0008, cout=0; SHR a=0005 n=1 -> y=0002, cout=1; SHL n=0 -> y=a, latency 1.
REQ-036 MUL a=0100 b=0100 -> done after edge k+16: y=0000, cout=1, zout=1; MUL a=0003 b=0007 -> y=0015, cout=0.
REQ-037 A start pulse during MUL is ignored (y is unchanged at completion); reset asserted mid-MUL, asynchronously between edges -> outputs at reset values immediately, no done pulse, then a new ADD completes normally.
REQ-038 Parameter sweep with WIDTH=8 and 32: random ops checked against a reference model, with latency checked per REQ-021/024/025.

Source files
------------

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - multi-cycle ALU: single-cycle logic/arith, serial shifter, shift-add multiplier
`timescale 1ns/1ps
module alu_multicycle #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             zout
);

  localparam int SW = $clog2(WIDTH);
  // Counter holds up to WIDTH (multiply iterations), so it needs one bit more than the shift field.
  localparam int CW = SW + 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  // lo_q is the shift register in SHIFT and the multiplier/product-low half in MUL.
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             cout_q, cout_d;
  logic             zout_q, zout_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] shift_val;
  logic             shift_bit;
  logic [WIDTH:0]   mul_sum;
  logic [CW-1:0]    cnt_dec;
  logic [SW-1:0]    shamt;
  logic             fin;
  logic [WIDTH-1:0] res;
  logic             res_c;

  // Next-state, datapath step and result publication; results reach y only when an operation finishes.
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    y_d     = y_q;
    cout_d  = cout_q;
    zout_d  = zout_q;
    done_d  = 1'b0;
    fin     = 1'b0;
    res     = '0;
    res_c   = 1'b0;

    shamt     = b[SW-1:0];
    b_eff     = (op == OP_SUB) ? ~b : b;
    sum_ext   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    shift_bit = dir_q ? lo_q[0] : lo_q[WIDTH-1];
    shift_val = dir_q ? {1'b0, lo_q[WIDTH-1:1]} : {lo_q[WIDTH-2:0], 1'b0};
    // One shift-add step: add multiplicand to high half when the current multiplier bit is set,
    // then shift the {carry, hi, lo} product right by one.
    mul_sum   = {1'b0, hi_q} + ({1'b0, mcand_q} & {(WIDTH+1){lo_q[0]}});
    cnt_dec   = cnt_q - CW'(1);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_ADD, OP_SUB: begin
              fin   = 1'b1;
              res   = sum_ext[WIDTH-1:0];
              res_c = sum_ext[WIDTH];
            end
            OP_AND: begin
              fin = 1'b1;
              res = a & b;
            end
            OP_OR: begin
              fin = 1'b1;
              res = a | b;
            end
            OP_XOR: begin
              fin = 1'b1;
              res = a ^ b;
            end
            OP_SHL, OP_SHR: begin
              if (shamt == '0) begin
                fin = 1'b1;
                res = a;
              end else begin
                lo_d    = a;
                cnt_d   = {1'b0, shamt};
                dir_d   = (op == OP_SHR);
                state_d = ST_SHIFT;
              end
            end
            OP_MUL: begin
              hi_d    = '0;
              lo_d    = b;
              mcand_d = a;
              cnt_d   = CW'(WIDTH);
              state_d = ST_MUL;
            end
            default: begin
              fin = 1'b0;
            end
          endcase
        end
      end

      ST_SHIFT: begin
        lo_d  = shift_val;
        cnt_d = cnt_dec;
        if (cnt_q == CW'(1)) begin
          fin     = 1'b1;
          res     = shift_val;
          res_c   = shift_bit;
          state_d = ST_IDLE;
        end
      end

      ST_MUL: begin
        hi_d  = mul_sum[WIDTH:1];
        lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_dec;
        if (cnt_q == CW'(1)) begin
          fin     = 1'b1;
          res     = {mul_sum[0], lo_q[WIDTH-1:1]};
          res_c   = |mul_sum[WIDTH:1];
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (fin) begin
      y_d    = res;
      cout_d = res_c;
      zout_d = (res == '0);
      done_d = 1'b1;
    end
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      y_q     <= '0;
      cout_q  <= 1'b0;
      zout_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      y_q     <= y_d;
      cout_q  <= cout_d;
      zout_q  <= zout_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign y    = y_q;
  assign cout = cout_q;
  assign zout = zout_q;

endmodule
